// File: rtl/expression_lanes_pkg.sv
// -----------------------------------------------------------------------------
// expression_lanes_pkg
// Shared types and constants for the multi-lane expression pipeline.
//   op_e        : 3-bit per-lane opcode
//   BEAT_CNT_W  : width of the saturating output-handshake counter
// -----------------------------------------------------------------------------
package expression_lanes_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_XOR  = 3'd3,
        OP_SHL  = 3'd4,
        OP_SHR  = 3'd5,
        OP_LT   = 3'd6,
        OP_RXOR = 3'd7
    } op_e;

    localparam int BEAT_CNT_W = 16;

endpackage

// File: rtl/expression_lane_alu.sv
// -----------------------------------------------------------------------------
// expression_lane_alu
// Combinational single-lane evaluator. Operands are read as signed when i_sgn
// is set, unsigned otherwise; the result is always truncated to W bits.
// Ports:
//   i_op  : opcode (op_e)
//   i_sgn : signed-interpretation flag
//   i_a   : operand A, W bits
//   i_b   : operand B, W bits (only b[2:0] is used as the shift amount)
//   o_y   : W-bit result
// -----------------------------------------------------------------------------
module expression_lane_alu
    import expression_lanes_pkg::*;
#(
    parameter int W = 6
) (
    input  op_e            i_op,
    input  logic           i_sgn,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [W-1:0]   o_y
);

    logic [2:0] w_sh;
    logic       w_lt;

    assign w_sh = i_b[2:0];

    // Both compare arms yield a 1-bit result; the signed arm only sees two
    // signed operands, so the comparison really is two's complement.
    assign w_lt = i_sgn ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // o_y unassigned, which would otherwise infer a latch.
        o_y = '0;
        case (i_op)
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_AND:  o_y = i_a & i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_SHL:  o_y = i_a << w_sh;
            // Kept as separate statements: inside a ?: with an unsigned arm
            // the signed shift would silently become a logical one.
            OP_SHR: begin
                if (i_sgn) o_y = $signed(i_a) >>> w_sh;
                else       o_y = i_a >> w_sh;
            end
            OP_LT:   o_y = {{(W-1){1'b0}}, w_lt};
            OP_RXOR: o_y = {{(W-1){1'b0}}, ^(i_a & i_b)};
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/expression_lanes_pipe.sv
// -----------------------------------------------------------------------------
// expression_lanes_pipe
// LANES independent expression evaluators feeding an elastic valid/ready
// pipeline of STAGES register stages. Bubbles collapse, so the pipeline
// sustains one beat per cycle; a stalled stage holds its contents.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : input beat valid         in_ready  : stage 1 can accept
//   op[3i+2:3i] : lane i opcode            sgn[i]    : lane i signed flag
//   a, b        : lane i operands at [W*i +: W]
//   out_valid   : last stage holds a beat  out_ready : consumer accepts
//   y           : packed lane results, lane 0 in the LSBs
//   beat_cnt    : saturating count of out_valid & out_ready handshakes
// Optional (macro EXPRESSION_LANES_PARITY_EN):
//   out_parity  : per-lane XOR of the result, travelling with its data
// -----------------------------------------------------------------------------
module expression_lanes_pipe
    import expression_lanes_pkg::*;
#(
    parameter int LANES  = 6,
    parameter int W      = 6,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3*LANES-1:0]     op,
    input  logic [LANES-1:0]       sgn,
    input  logic [W*LANES-1:0]     a,
    input  logic [W*LANES-1:0]     b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W*LANES-1:0]     y,
    output logic [BEAT_CNT_W-1:0]  beat_cnt
`ifdef EXPRESSION_LANES_PARITY_EN
    ,
    output logic [LANES-1:0]       out_parity
`endif
);

    localparam int DW = W * LANES;

    logic [DW-1:0]         w_result;
    logic [DW-1:0]         w_src_data [STAGES];
    logic [DW-1:0]         r_data     [STAGES];
    logic [STAGES-1:0]     w_src_valid;
    logic [STAGES-1:0]     r_valid;
    logic [STAGES:0]       w_ready;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;

    // ---------------------------------------------------------------- lanes
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        expression_lane_alu #(
            .W (W)
        ) u_alu (
            .i_op  (op_e'(op[3*i +: 3])),
            .i_sgn (sgn[i]),
            .i_a   (a[W*i +: W]),
            .i_b   (b[W*i +: W]),
            .o_y   (w_result[W*i +: W])
        );
    end

    // ------------------------------------------------------- ready chain
    // A stage may load when it is empty or its successor is loading too;
    // computed from the output back towards the input.
    always_comb begin
        w_ready         = '0;
        w_ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_ready[k] = ~r_valid[k] | w_ready[k+1];
        end
    end

    // Each stage's source: the lane results for stage 0, the previous
    // stage's register otherwise.
    always_comb begin
        w_src_valid    = '0;
        w_src_data     = '{default: '0};
        w_src_valid[0] = in_valid;
        w_src_data[0]  = w_result;
        for (int k = 1; k < STAGES; k++) begin
            w_src_valid[k] = r_valid[k-1];
            w_src_data[k]  = r_data[k-1];
        end
    end

    // ---------------------------------------------------- stage registers
    // NOTE: the data registers are reset as well, because y must read zero
    // straight out of reset rather than whatever the flops powered up with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ready[k]) begin
                    // NOTE: non-blocking, so every stage samples its
                    // predecessor's pre-edge value and beats shift by one.
                    r_valid[k] <= w_src_valid[k];
                    // Data only moves with a real beat: y holds through bubbles.
                    if (w_src_valid[k]) begin
                        r_data[k] <= w_src_data[k];
                    end
                end
            end
        end
    end

    // -------------------------------------------------- handshake counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (out_valid && out_ready && (r_beat_cnt != '1)) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

`ifdef EXPRESSION_LANES_PARITY_EN
    // ------------------------------------------------------ lane parity
    logic [LANES-1:0] w_parity;
    logic [LANES-1:0] w_src_par [STAGES];
    logic [LANES-1:0] r_par     [STAGES];

    for (genvar i = 0; i < LANES; i++) begin : g_par
        assign w_parity[i] = ^w_result[W*i +: W];
    end

    always_comb begin
        w_src_par    = '{default: '0};
        w_src_par[0] = w_parity;
        for (int k = 1; k < STAGES; k++) begin
            w_src_par[k] = r_par[k-1];
        end
    end

    // Same load rule as the data registers so parity stays with its beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_par[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ready[k] && w_src_valid[k]) begin
                    r_par[k] <= w_src_par[k];
                end
            end
        end
    end

    assign out_parity = r_par[STAGES-1];
`endif

    // ------------------------------------------------------------ outputs
    assign in_ready  = w_ready[0];
    assign out_valid = r_valid[STAGES-1];
    assign y         = r_data[STAGES-1];
    assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_expression_lanes_pipe.sv
// -----------------------------------------------------------------------------
// tb_expression_lanes_pipe
// Self-checking bench for expression_lanes_pipe at its default parameters.
// Expected results come from an integer-arithmetic lane model and a FIFO
// scoreboard; directed steps cover reset, opcode corner cases, latency,
// capacity/backpressure, then a randomized stream.
// -----------------------------------------------------------------------------
module tb_expression_lanes_pipe;
    import expression_lanes_pkg::*;

    localparam int LANES   = 6;
    localparam int W       = 6;
    localparam int STAGES  = 2;
    localparam int DW      = LANES * W;
    localparam int OPW     = 3 * LANES;
    localparam int N_BEATS = 1000;

    logic                  clk       = 1'b0;
    logic                  rst_n     = 1'b0;
    logic                  in_valid  = 1'b0;
    logic                  out_ready = 1'b0;
    logic [OPW-1:0]        op        = '0;
    logic [LANES-1:0]      sgn       = '0;
    logic [DW-1:0]         a         = '0;
    logic [DW-1:0]         b         = '0;
    logic                  in_ready;
    logic                  out_valid;
    logic [DW-1:0]         y;
    logic [BEAT_CNT_W-1:0] beat_cnt;
`ifdef EXPRESSION_LANES_PARITY_EN
    logic [LANES-1:0]      out_parity;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] bp_exp [4];

    expression_lanes_pipe #(
        .LANES  (LANES),
        .W      (W),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .sgn       (sgn),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .beat_cnt  (beat_cnt)
`ifdef EXPRESSION_LANES_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------ reference model
    function automatic logic [W-1:0] ref_lane(input int opv, input bit s,
                                               input logic [W-1:0] av,
                                               input logic [W-1:0] bv);
        longint m, x, z, p, r;
        logic [2:0] sh;
        m  = longint'(1) << W;
        x  = (s && av[W-1]) ? longint'(av) - m : longint'(av);
        z  = (s && bv[W-1]) ? longint'(bv) - m : longint'(bv);
        sh = bv[2:0];
        p  = longint'(1) << sh;
        case (opv)
            0: r = x + z;
            1: r = x - z;
            2: r = longint'(av & bv);
            3: r = longint'(av ^ bv);
            4: r = x * p;
            5: begin
                if (!s)        r = longint'(av) / p;
                else if (x >= 0) r = x / p;
                else           r = -((-x + p - 1) / p);   // floor division
            end
            6: r = (x < z) ? 1 : 0;
            default: r = longint'($countones(av & bv) % 2);
        endcase
        return r[W-1:0];
    endfunction

    function automatic logic [DW-1:0] ref_y(input logic [OPW-1:0] opv,
                                            input logic [LANES-1:0] sv,
                                            input logic [DW-1:0] av,
                                            input logic [DW-1:0] bv);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[W*i +: W] = ref_lane(int'(opv[3*i +: 3]), sv[i],
                                   av[W*i +: W], bv[W*i +: W]);
        end
        return r;
    endfunction

    // ------------------------------------------------------------- helpers
    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        op  = '0;
        sgn = '0;
        a   = '0;
        b   = '0;
    endtask

    task automatic set_lane(input int lane, input int opv, input bit s,
                            input int av, input int bv);
        op[3*lane +: 3] = 3'(opv);
        sgn[lane]       = s;
        a[W*lane +: W]  = W'(av);
        b[W*lane +: W]  = W'(bv);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
    endtask

    // One beat into an empty pipeline with out_ready=1: checks the exact
    // latency and the selected lane's result against a literal value.
    task automatic directed(input string tag, input int lane, input int opv,
                            input bit s, input int av, input int bv,
                            input int exp);
        @(negedge clk);
        clear_inputs();
        set_lane(lane, opv, s, av, bv);
        in_valid = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 1; c < STAGES; c++) begin
            #1 check({tag, "_early"}, 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        #1 check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check(tag, 64'(y[W*lane +: W]), 64'(exp));
    endtask

    task automatic drive_bp(input int k);
        clear_inputs();
        set_lane(0, 0, 1'b0, 10 + k, k);
        in_valid  = 1'b1;
        bp_exp[k] = ref_y(op, sgn, a, b);
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        int sent;
        int recvd;
        int cyc;
        logic [DW-1:0] exp_y;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);

        // Opcode corner cases, latency STAGES
        directed("add_wrap",   0, 0, 1'b0, 40, 30, 6);
        directed("sub_wrap",   0, 1, 1'b0, 3, 5, 62);
        directed("shr_arith",  1, 5, 1'b1, 6'b110000, 2, 6'b111100);
        directed("shr_logic",  1, 5, 1'b0, 6'b110000, 2, 6'b001100);
        directed("lt_signed",  2, 6, 1'b1, 6'h3F, 1, 1);
        directed("lt_unsigned", 2, 6, 1'b0, 6'h3F, 1, 0);
        @(negedge clk);
        #1 check("directed_beat_cnt", 64'(beat_cnt), 64'd6);

        // Reset mid-stream with two beats in flight
        out_ready = 1'b0;
        @(negedge clk);
        clear_inputs();
        set_lane(0, 0, 1'b0, 7, 1);
        in_valid = 1'b1;
        @(negedge clk);
        set_lane(0, 0, 1'b0, 9, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("mid_full", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_y", 64'(y), 64'd0);
        check("mid_rst_beat_cnt", 64'(beat_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 check("mid_rel_in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1 check("mid_no_ghost", 64'(out_valid), 64'd0);
        end
        check("mid_cnt_after", 64'(beat_cnt), 64'd0);

        // Capacity and backpressure
        reset_dut();
        out_ready = 1'b0;
        @(negedge clk);
        drive_bp(0);
        #1 check("bp_acc0", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive_bp(1);
        #1 check("bp_acc1", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive_bp(2);
        #1 check("bp_full", 64'(in_ready), 64'd0);
        check("bp_head", 64'(y), 64'(bp_exp[0]));
        @(negedge clk);
        #1 check("bp_hold_rdy", 64'(in_ready), 64'd0);
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_y", 64'(y), 64'(bp_exp[0]));
        out_ready = 1'b1;
        #1 check("bp_pass_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive_bp(3);
        #1 check("bp_out1", 64'(y), 64'(bp_exp[1]));
        check("bp_out1_valid", 64'(out_valid), 64'd1);
        check("bp_acc3", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("bp_out2", 64'(y), 64'(bp_exp[2]));
        check("bp_out2_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        #1 check("bp_out3", 64'(y), 64'(bp_exp[3]));
        check("bp_out3_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        #1 check("bp_empty", 64'(out_valid), 64'd0);
        check("bp_y_hold", 64'(y), 64'(bp_exp[3]));
        check("bp_beat_cnt", 64'(beat_cnt), 64'd4);

        // Randomized stream with random backpressure
        reset_dut();
        sent  = 0;
        recvd = 0;
        cyc   = 0;
        while ((sent < N_BEATS || recvd < N_BEATS) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < N_BEATS) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            op        = OPW'($urandom);
            sgn       = LANES'($urandom);
            a         = DW'({$urandom, $urandom});
            b         = DW'({$urandom, $urandom});
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stream_unexpected_beat", 64'(y), 64'd0 - 64'd1);
                end else begin
                    exp_y = q.pop_front();
                    check("stream_y", 64'(y), 64'(exp_y));
`ifdef EXPRESSION_LANES_PARITY_EN
                    for (int i = 0; i < LANES; i++) begin
                        check("stream_parity", 64'(out_parity[i]),
                              64'(^exp_y[W*i +: W]));
                    end
`endif
                end
                recvd++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_y(op, sgn, a, b));
                sent++;
            end
        end
        in_valid = 1'b0;
        check("stream_sent", 64'(sent), 64'(N_BEATS));
        check("stream_recvd", 64'(recvd), 64'(N_BEATS));
        check("stream_queue_empty", 64'(q.size()), 64'd0);
        @(negedge clk);
        #1 check("stream_beat_cnt", 64'(beat_cnt), 64'(N_BEATS));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
